// File: rtl/prod_accum_pkg.sv
// ============================================================================
// Module   : prod_accum_pkg
// Purpose  : Shared widths, FSM encoding and 2-bit product helper used by the
//            multiplier front end and the product accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package prod_accum_pkg;

  localparam int PROD_W  = 4;
  localparam int OPND_W  = 2;
  localparam int TERMS_W = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  // Shift-and-add of two 2-bit operands; max result 9 fits PROD_W.
  function automatic logic [PROD_W-1:0] mul2(input logic [OPND_W-1:0] a,
                                             input logic [OPND_W-1:0] b);
    logic [PROD_W-1:0] pp0;
    logic [PROD_W-1:0] pp1;
    pp0 = {2'b00, a & {OPND_W{b[0]}}};
    pp1 = {1'b0, a & {OPND_W{b[1]}}, 1'b0};
    return pp0 + pp1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prod_accum_mul2.sv
// ============================================================================
// Module   : prod_accum_mul2
// Purpose  : Combinational 2x2-bit multiplier that feeds prod_accum.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accum_mul2
  import prod_accum_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = mul2(a, b);

endmodule

`default_nettype wire

// File: rtl/prod_accum.sv
// ============================================================================
// Module   : prod_accum
// Purpose  : Sums N_TERMS 4-bit products per result and presents the total
//            on a valid/ready output with a sticky wrap flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prod_accum
  import prod_accum_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [PROD_W-1:0]  prod_in,
  input  logic               prod_valid,
  output logic               prod_ready,
  output logic [ACC_W-1:0]   sum_out,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               overflow,
  output logic [TERMS_W-1:0] terms
);

  localparam logic [TERMS_W-1:0] c_last_term = TERMS_W'(N_TERMS - 1);

  state_e               r_state;
  logic [ACC_W-1:0]     r_acc;
  logic [TERMS_W-1:0]   r_terms;
  logic                 r_overflow;

  logic [ACC_W:0]       w_sum;
  logic                 w_accept;
  logic                 w_consume;
  logic                 w_last;

  // One extra bit so the carry out of the accumulator is visible.
  assign w_sum     = {1'b0, r_acc} + (ACC_W+1)'(prod_in);
  assign w_accept  = prod_valid && (r_state == ST_ACCUM);
  assign w_consume = sum_ready && (r_state == ST_HOLD);
  assign w_last    = (r_terms == c_last_term);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_terms    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= ST_ACCUM;
      r_acc      <= '0;
      r_terms    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            r_acc   <= w_sum[ACC_W-1:0];
            r_terms <= r_terms + 8'd1;
            if (w_sum[ACC_W]) begin
              r_overflow <= 1'b1;
            end
            if (w_last) begin
              r_state <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (w_consume) begin
            r_state    <= ST_ACCUM;
            r_acc      <= '0;
            r_terms    <= '0;
            r_overflow <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_ACCUM;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign prod_ready = (r_state == ST_ACCUM);
  assign sum_valid  = (r_state == ST_HOLD);
  assign sum_out    = r_acc;
  assign overflow   = r_overflow;
  assign terms      = r_terms;

endmodule

`default_nettype wire

// File: tb/tb_prod_accum.sv
// Directed bench for prod_accum: three instances (N4/W8, N4/W5, N1/W8) checked
// against a scoreboard of expected results.
`default_nettype none

module tb_prod_accum;

  logic clk;
  logic rst_n;

  // DUT A: N_TERMS=4, ACC_W=8
  logic       a_clear, a_pv, a_sr, a_pr, a_sv, a_ovf;
  logic [3:0] a_pin;
  logic [7:0] a_sum, a_terms;
  // DUT B: N_TERMS=4, ACC_W=5
  logic       b_clear, b_pv, b_sr, b_pr, b_sv, b_ovf;
  logic [3:0] b_pin;
  logic [4:0] b_sum;
  logic [7:0] b_terms;
  // DUT C: N_TERMS=1, ACC_W=8, fed by the 2-bit multiplier
  logic       c_clear, c_pv, c_sr, c_pr, c_sv, c_ovf;
  logic [1:0] c_opa, c_opb;
  logic [3:0] c_pin;
  logic [7:0] c_sum, c_terms;

  prod_accum #(.N_TERMS(4), .ACC_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear), .prod_in(a_pin),
    .prod_valid(a_pv), .prod_ready(a_pr), .sum_out(a_sum), .sum_valid(a_sv),
    .sum_ready(a_sr), .overflow(a_ovf), .terms(a_terms));

  prod_accum #(.N_TERMS(4), .ACC_W(5)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear), .prod_in(b_pin),
    .prod_valid(b_pv), .prod_ready(b_pr), .sum_out(b_sum), .sum_valid(b_sv),
    .sum_ready(b_sr), .overflow(b_ovf), .terms(b_terms));

  prod_accum_mul2 u_mul (.a(c_opa), .b(c_opb), .p(c_pin));

  prod_accum #(.N_TERMS(1), .ACC_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .clear(c_clear), .prod_in(c_pin),
    .prod_valid(c_pv), .prod_ready(c_pr), .sum_out(c_sum), .sum_valid(c_sv),
    .sum_ready(c_sr), .overflow(c_ovf), .terms(c_terms));

  logic [2:0]  sv_v;
  logic [2:0]  ovf_v;
  logic [15:0] sum_v [3];
  logic [7:0]  terms_v [3];
  assign sv_v       = {c_sv, b_sv, a_sv};
  assign ovf_v      = {c_ovf, b_ovf, a_ovf};
  assign sum_v[0]   = 16'(a_sum);
  assign sum_v[1]   = 16'(b_sum);
  assign sum_v[2]   = 16'(c_sum);
  assign terms_v[0] = a_terms;
  assign terms_v[1] = b_terms;
  assign terms_v[2] = c_terms;

  typedef struct packed {
    logic [1:0]  dut;
    logic [15:0] sum;
    logic        ovf;
    logic [7:0]  terms;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input int s, input logic o, input int t);
    exp_t e;
    e.dut   = 2'(d);
    e.sum   = 16'(s);
    e.ovf   = o;
    e.terms = 8'(t);
    q.push_back(e);
  endtask

  // Pops the oldest expectation and waits (bounded) for its DUT to present it.
  task automatic check_result(input string tag);
    exp_t e;
    e = q.pop_front();
    for (int i = 0; i < 16 && !sv_v[e.dut]; i++) tick();
    chk({tag, "_valid"}, 32'(sv_v[e.dut]), 1);
    chk({tag, "_sum"}, 32'(sum_v[e.dut]), 32'(e.sum));
    chk({tag, "_ovf"}, 32'(ovf_v[e.dut]), 32'(e.ovf));
    chk({tag, "_terms"}, 32'(terms_v[e.dut]), 32'(e.terms));
  endtask

  task automatic hs_a();
    a_sr = 1'b1;
    tick();
    a_sr = 1'b0;
  endtask

  task automatic hs_b();
    b_sr = 1'b1;
    tick();
    b_sr = 1'b0;
  endtask

  task automatic feed_a(input int v);
    a_pv  = 1'b1;
    a_pin = 4'(v);
    tick();
    a_pv  = 1'b0;
  endtask

  initial begin
    int gaps [7];
    int pa, pb;
    gaps = '{2, -1, 3, -1, -1, 1, 6};
    rst_n = 1'b0;
    {a_clear, a_pv, a_sr, a_pin} = '0;
    {b_clear, b_pv, b_sr, b_pin} = '0;
    {c_clear, c_pv, c_opa, c_opb} = '0;
    c_sr = 1'b1;
    tick();
    tick();
    chk("rst_ready", 32'(a_pr), 1);
    chk("rst_valid", 32'(a_sv), 0);
    chk("rst_sum", 32'(a_sum), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    chk("rst_terms", 32'(a_terms), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_terms", 32'(a_terms), 0);

    // Basic sum 9*4 = 36
    push(0, 36, 1'b0, 4);
    a_pv = 1'b1; a_pin = 4'd9;
    tick(); tick(); tick();
    chk("basic_no_early_valid", 32'(a_sv), 0);
    chk("basic_partial", 32'(a_sum), 27);
    tick();
    a_pv = 1'b0;
    chk("basic_latency", 32'(a_sv), 1);
    chk("basic_ready_low", 32'(a_pr), 0);
    check_result("basic");
    hs_a();
    chk("basic_after_ready", 32'(a_pr), 1);
    chk("basic_after_sum", 32'(a_sum), 0);
    chk("basic_after_terms", 32'(a_terms), 0);

    // Overflow on ACC_W=5: 36 mod 32 = 4
    push(1, 4, 1'b1, 4);
    b_pv = 1'b1; b_pin = 4'd9;
    tick(); tick(); tick();
    chk("ovf_not_yet", 32'(b_ovf), 0);
    tick();
    b_pv = 1'b0;
    check_result("ovf");
    hs_b();
    chk("ovf_cleared", 32'(b_ovf), 0);
    push(1, 4, 1'b0, 4);
    b_pv = 1'b1; b_pin = 4'd1;
    tick(); tick(); tick(); tick();
    b_pv = 1'b0;
    check_result("ovf_next");
    hs_b();

    // Backpressure: 1+2+3+4 = 10 held while prod_valid offers 5
    push(0, 10, 1'b0, 4);
    feed_a(1); feed_a(2); feed_a(3); feed_a(4);
    check_result("bp");
    a_pv = 1'b1; a_pin = 4'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_ready_low", 32'(a_pr), 0);
      chk("bp_sum_stable", 32'(a_sum), 10);
      chk("bp_terms_stable", 32'(a_terms), 4);
    end
    a_sr = 1'b1;
    tick();
    a_sr = 1'b0;
    chk("bp_hs_terms", 32'(a_terms), 0);
    chk("bp_hs_ready", 32'(a_pr), 1);
    tick();
    chk("bp_first_terms", 32'(a_terms), 1);
    chk("bp_first_sum", 32'(a_sum), 5);
    push(0, 20, 1'b0, 4);
    tick(); tick(); tick();
    a_pv = 1'b0;
    check_result("bp_next");
    hs_a();

    // Gaps: 2,_,3,_,_,1,6 = 12
    push(0, 12, 1'b0, 4);
    foreach (gaps[i]) begin
      a_pv  = (gaps[i] >= 0);
      a_pin = (gaps[i] >= 0) ? 4'(gaps[i]) : 4'd15;
      tick();
    end
    a_pv = 1'b0;
    check_result("gaps");
    hs_a();

    // Synchronous clear beats a same-cycle accept
    feed_a(3); feed_a(4);
    a_clear = 1'b1; a_pv = 1'b1; a_pin = 4'd7;
    tick();
    a_clear = 1'b0; a_pv = 1'b0;
    chk("clr_terms", 32'(a_terms), 0);
    chk("clr_sum", 32'(a_sum), 0);
    chk("clr_ready", 32'(a_pr), 1);
    // Clear in HOLD drops the result being consumed
    feed_a(1); feed_a(1); feed_a(1); feed_a(1);
    chk("clr_hold_valid", 32'(a_sv), 1);
    a_clear = 1'b1; a_sr = 1'b1;
    tick();
    a_clear = 1'b0; a_sr = 1'b0;
    chk("clr_hold_dropped", 32'(a_sv), 0);
    chk("clr_hold_sum", 32'(a_sum), 0);

    // Asynchronous reset between edges
    feed_a(3); feed_a(4);
    chk("arst_pre_sum", 32'(a_sum), 7);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum", 32'(a_sum), 0);
    chk("arst_terms", 32'(a_terms), 0);
    chk("arst_ready", 32'(a_pr), 1);
    chk("arst_valid", 32'(a_sv), 0);
    #1 rst_n = 1'b1;
    tick();

    // N_TERMS=1 streaming through the multiplier, sum_ready tied high
    c_pv = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 3) begin
        pa = 1; pb = i + 1;
      end else begin
        pa = int'($urandom_range(0, 3));
        pb = int'($urandom_range(0, 3));
      end
      c_opa = 2'(pa);
      c_opb = 2'(pb);
      push(2, pa * pb, 1'b0, 1);
      chk("str_ready_hi", 32'(c_pr), 1);
      tick();
      chk("str_ready_lo", 32'(c_pr), 0);
      check_result("str");
      tick();
    end
    c_pv = 1'b0;

    chk("sb_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
